// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/MEM stages, the port arbiter and the unified RAM.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_ADDR_W = 12
);
  logic                  i_if_req;
  logic [31:0]           i_if_addr;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [31:0]           o_if_rdata;

  logic                  i_d_req;
  logic                  i_d_we;
  logic [31:0]           i_d_addr;
  logic [31:0]           i_d_wdata;
  logic [3:0]            i_d_mask_sel;
  logic                  o_d_gnt;
  logic                  o_d_rvalid;
  logic [31:0]           o_d_rdata;
  logic                  o_d_err;

  logic                  o_mem_en;
  logic [3:0]            o_mem_we;
  logic [MEM_ADDR_W-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic [31:0]           i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_mask_sel,
           i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_mask_sel,
           i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store, with per-cycle
// fair arbitration, store lane replication and load sign/zero extension.
module mem_port_arbiter #(
  parameter int unsigned MEM_ADDR_W = 12
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] MemLb  = 4'd0;
  localparam logic [3:0] MemLh  = 4'd1;
  localparam logic [3:0] MemLw  = 4'd2;
  localparam logic [3:0] MemLbu = 4'd3;
  localparam logic [3:0] MemLhu = 4'd4;
  localparam logic [3:0] MemSb  = 4'd5;
  localparam logic [3:0] MemSh  = 4'd6;
  localparam logic [3:0] MemSw  = 4'd7;

  typedef enum logic {GntIf, GntD} gnt_e;

  gnt_e       last_gnt_q, last_gnt_d;
  logic       rsp_if_q, rsp_if_d;
  logic       rsp_d_q, rsp_d_d;
  logic       err_q, err_d;
  logic [3:0] code_q;
  logic [1:0] off_q;

  logic       if_req, d_req, if_gnt, d_gnt;
  logic       is_load, is_store, d_illegal;
  logic [3:0] sel;
  logic [1:0] d_off;

  // Address bits outside the RAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_if_addr[1:0], bus.i_if_addr[31:MEM_ADDR_W+2],
                              bus.i_d_addr[31:MEM_ADDR_W+2]};

  assign sel   = bus.i_d_mask_sel;
  assign d_off = bus.i_d_addr[1:0];

  always_comb begin
    is_load   = (sel <= MemLhu);
    is_store  = (sel == MemSb) || (sel == MemSh) || (sel == MemSw);
    d_illegal = !(is_load || is_store)
             || (is_store && !bus.i_d_we)
             || (is_load && bus.i_d_we)
             || (((sel == MemLw) || (sel == MemSw)) && (d_off != 2'b00))
             || (((sel == MemLh) || (sel == MemLhu) || (sel == MemSh)) && d_off[0]);
  end

  // Nothing is granted while reset is held.
  assign if_req = bus.i_if_req & rst_n;
  assign d_req  = bus.i_d_req & rst_n;
  assign d_gnt  = d_req & (!if_req || (last_gnt_q == GntIf));
  assign if_gnt = if_req & !d_gnt;

  assign bus.o_if_gnt = if_gnt;
  assign bus.o_d_gnt  = d_gnt;

  always_comb begin
    bus.o_mem_en    = 1'b0;
    bus.o_mem_we    = 4'b0000;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (if_gnt) begin
      bus.o_mem_en   = 1'b1;
      bus.o_mem_addr = bus.i_if_addr[MEM_ADDR_W+1:2];
    end else if (d_gnt && !d_illegal) begin
      bus.o_mem_en   = 1'b1;
      bus.o_mem_addr = bus.i_d_addr[MEM_ADDR_W+1:2];
      case (sel)
        MemSb: begin
          bus.o_mem_we    = 4'b0001 << d_off;
          bus.o_mem_wdata = {4{bus.i_d_wdata[7:0]}};
        end
        MemSh: begin
          bus.o_mem_we    = d_off[1] ? 4'b1100 : 4'b0011;
          bus.o_mem_wdata = {2{bus.i_d_wdata[15:0]}};
        end
        MemSw: begin
          bus.o_mem_we    = 4'b1111;
          bus.o_mem_wdata = bus.i_d_wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (d_gnt) begin
      last_gnt_d = GntD;
    end else if (if_gnt) begin
      last_gnt_d = GntIf;
    end
    rsp_if_d = if_gnt;
    rsp_d_d  = d_gnt && !d_illegal && is_load;
    err_d    = d_gnt && d_illegal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q <= GntIf;
      rsp_if_q   <= 1'b0;
      rsp_d_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 4'd0;
      off_q      <= 2'd0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_if_q   <= rsp_if_d;
      rsp_d_q    <= rsp_d_d;
      err_q      <= err_d;
      if (d_gnt) begin
        code_q <= sel;
        off_q  <= d_off;
      end
    end
  end

  logic [31:0] shifted, d_fmt;

  always_comb begin
    shifted = bus.i_mem_rdata >> {off_q, 3'b000};
    case (code_q)
      MemLb:   d_fmt = {{24{shifted[7]}}, shifted[7:0]};
      MemLh:   d_fmt = {{16{shifted[15]}}, shifted[15:0]};
      MemLbu:  d_fmt = {24'd0, shifted[7:0]};
      MemLhu:  d_fmt = {16'd0, shifted[15:0]};
      default: d_fmt = shifted;
    endcase
  end

  // Gating with rst_n drops a response whose cycle is overlapped by reset.
  assign bus.o_if_rvalid = rsp_if_q & rst_n;
  assign bus.o_d_rvalid  = rsp_d_q & rst_n;
  assign bus.o_d_err     = err_q & rst_n;
  assign bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rdata : 32'd0;
  assign bus.o_d_rdata   = bus.o_d_rvalid ? d_fmt : 32'd0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous data/instruction RAM port between the instruction fetch unit and the load/store unit. Arbitrates per cycle, converts `MEM_*` mask-select codes into byte enables and lane-replicated write data, and formats load return data with sign/zero extension. Sits between the IF/MEM pipeline stages and the unified RAM macro, sustaining one access per cycle with fixed one-cycle read latency.

## Interface
- `MEM_ADDR_W`, default 12: word-address width presented to the RAM. Capacity is 4·2^MEM_ADDR_W bytes.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `i_if_req` in 1: fetch request. Held with stable address until granted.
- `i_if_addr` in 32: fetch byte address. Bits [1:0] are ignored; fetches are word accesses.
- `o_if_gnt` out 1: fetch accepted this cycle (combinational).
- `o_if_rvalid` out 1: fetch data valid.
- `o_if_rdata` out 32: fetched instruction word.
- `i_d_req` in 1: data request. Held with stable fields until granted.
- `i_d_we` in 1: 1 = store, 0 = load.
- `i_d_addr` in 32: data byte address.
- `i_d_wdata` in 32: store data, right-aligned (byte/half in the low bits).
- `i_d_mask_sel` in 4: `MEM_*` code: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7.
- `o_d_gnt` out 1: data request accepted this cycle (combinational).
- `o_d_rvalid` out 1: load data valid (loads only).
- `o_d_rdata` out 32: extended load data.
- `o_d_err` out 1: one-cycle pulse reporting a misaligned or illegal request.
- `o_mem_en` out 1: RAM access enable.
- `o_mem_we` out 4: RAM byte write enables.
- `o_mem_addr` out MEM_ADDR_W: RAM word address, `addr[MEM_ADDR_W+1:2]`.
- `o_mem_wdata` out 32: lane-replicated store data.
- `i_mem_rdata` in 32: RAM read data, valid the cycle after `o_mem_en`.

## Operation
**Arbitration**
- At most one grant per cycle.
- If only one side requests, that side is granted.
- If both request, the side not granted most recently wins.
- The last-grant register resets to IF, so data wins the first conflict after reset.
- The last-grant register updates only on a grant.

**Data request legality.** A data request is illegal if any of the following hold:
- `i_d_mask_sel` ≥ 8.
- A store code (5–7) with `i_d_we`=0, or a load code (0–4) with `i_d_we`=1.
- LW/SW with `addr[1:0]`≠0.
- LH/LHU/SH with `addr[0]`≠0.

An illegal request is still granted, with `o_mem_en`=0. `o_d_err` pulses the next cycle, and `o_d_rvalid` stays 0 for it.

**Stores**
- SB: `o_mem_we` = 4'b0001 << addr[1:0]; `o_mem_wdata` = {4{wdata[7:0]}}.
- SH: `o_mem_we` = 4'b0011 << (2·addr[1]); `o_mem_wdata` = {2{wdata[15:0]}}.
- SW: `o_mem_we` = 4'b1111; `o_mem_wdata` = wdata.
- A store completes at grant and produces no rvalid.

**Loads and fetches**
- `o_mem_we` = 0 and `o_mem_en` = 1.
- The requester id, load code and `addr[1:0]` are registered at grant.
- Next cycle, the raw word is shifted right by 8·offset.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW and fetches pass the word unchanged.

**RAM outputs**
- `o_mem_*` are combinational from the granted request.
- When nothing is granted, all `o_mem_*` are 0.

## Timing
- Grant in cycle N (combinational from the requests).
- RAM samples address and enable at the end of N.
- `o_*_rvalid`, `o_*_rdata` and `o_d_err` are valid in N+1 (valid/err flags registered; rdata formatted from `i_mem_rdata`).
- Throughput: one access per cycle. Back-to-back grants may alternate sides with no bubble.
- Response outputs do not depend on the current-cycle requests, so a response in N+1 and a new grant in N+1 coexist.
- Reset values: `o_if_gnt`, `o_d_gnt`, `o_if_rvalid`, `o_d_rvalid`, `o_d_err`, `o_mem_en` and `o_mem_we` are 0. `o_if_rdata` and `o_d_rdata` are 0 whenever their rvalid is 0. The last-grant register is IF.
- Reset asserted while a response is pending drops that response; no rvalid or err appears after reset.
- No requests are granted while `rst_n`=0.
- Requesters must not deassert or change request fields before grant. Behaviour under such changes is undefined and is not checked.

## Test plan
- **Fetch only.** if_req with addr 0x0000_0010; RAM word 4 = 0x0000_0013.
  - Required: gnt in N, `o_mem_addr`=4, `o_if_rvalid`=1 with rdata 0x0000_0013 in N+1.
- **Conflict fairness.** Both sides request continuously for 4 cycles from reset.
  - Required: grant order D, IF, D, IF, with a matching rvalid sequence one cycle behind.
- **Stores.**
  - SB, addr 0x103, wdata 0x0000_00A5 → `o_mem_we`=4'b1000, `o_mem_wdata`=0xA5A5_A5A5, `o_mem_addr`=0x40.
  - SH, addr 0x102, wdata 0x1234 → we=4'b1100, wdata=0x1234_1234.
- **Load extension.** RAM word = 0x80F1_7F82.
  - LB at offset 0 → 0xFFFF_FF82.
  - LBU at offset 0 → 0x0000_0082.
  - LH at offset 2 → 0xFFFF_80F1.
  - LHU at offset 2 → 0x0000_80F1.
  - LW at offset 0 → 0x80F1_7F82.
- **Errors.** LW at addr 0x102; SH at 0x101; mask_sel 9; SW code with we=0.
  - Required for each: gnt=1, `o_mem_en`=0, `o_d_err` pulse in N+1, no rvalid.
- **Reset mid-operation.** Load granted in N; `rst_n`=0 in N+1.
  - Required: no rvalid or err in N+1 or later, all outputs 0.
  - After release with both sides requesting, data is granted first.
